// File: rtl/nios2_mul_seq_arbiter_if.sv
// Requester, response and multiplier-cell signals of the
// sequenced multiply arbiter, grouped for modport use.
interface nios2_mul_seq_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_src1;
    logic [31:0] req0_src2;
    logic [1:0]  req0_op;
    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_src1;
    logic [31:0] req1_src2;
    logic [1:0]  req1_op;
    logic [15:0] mc_a;
    logic [15:0] mc_b;
    logic [31:0] mc_p;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_result;
    logic        resp_id;

    modport slave (
        input  req0_valid, req0_src1, req0_src2, req0_op,
        input  req1_valid, req1_src1, req1_src2, req1_op,
        input  mc_p, resp_ready,
        output req0_ready, req1_ready, mc_a, mc_b,
        output resp_valid, resp_result, resp_id
    );

    modport master (
        output req0_valid, req0_src1, req0_src2, req0_op,
        output req1_valid, req1_src1, req1_src2, req1_op,
        output mc_p, resp_ready,
        input  req0_ready, req1_ready, mc_a, mc_b,
        input  resp_valid, resp_result, resp_id
    );
endinterface

// File: rtl/nios2_mul_seq_arbiter.sv
// 32x32 multiply sequencer over a shared 16x16 cell,
// round-robin arbitrated between two requesters.
module nios2_mul_seq_arbiter #(
    parameter int MUL_LATENCY = 1
) (
    input logic                      clk,
    input logic                      reset_n,
    nios2_mul_seq_arbiter_if.slave   bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_DRAIN, S_CORR, S_DONE
    } state_t;

    state_t      r_state;
    logic        r_rr;
    logic        r_id;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [1:0]  r_op;
    logic [1:0]  r_cnt;
    logic [63:0] r_acc;
    logic [15:0] r_mc_a;
    logic [15:0] r_mc_b;

    logic [MUL_LATENCY-1:0] r_tv;
    logic [MUL_LATENCY-1:0] r_tl;
    logic [1:0]             r_ts [MUL_LATENCY];

    logic        w_gnt;
    logic        w_take;
    logic [31:0] w_a_in;
    logic [31:0] w_b_in;
    logic [1:0]  w_op_in;
    logic        w_last;
    logic [1:0]  w_nxt_cnt;
    logic [15:0] w_nxt_a;
    logic [15:0] w_nxt_b;
    logic [1:0]  w_sh_in;
    logic [63:0] w_prod;
    logic [63:0] w_acc_nxt;
    logic        w_ptv;
    logic        w_ptl;
    logic [31:0] w_hi_corr;

    assign w_gnt = (bus.req0_valid & bus.req1_valid) ? r_rr
                 : ~bus.req0_valid;
    assign w_take = (r_state == S_IDLE)
                  & (bus.req0_valid | bus.req1_valid);

    assign bus.req0_ready = reset_n & (r_state == S_IDLE)
                          & bus.req0_valid & ~w_gnt;
    assign bus.req1_ready = reset_n & (r_state == S_IDLE)
                          & bus.req1_valid & w_gnt;

    assign w_a_in  = w_gnt ? bus.req1_src1 : bus.req0_src1;
    assign w_b_in  = w_gnt ? bus.req1_src2 : bus.req0_src2;
    assign w_op_in = w_gnt ? bus.req1_op   : bus.req0_op;

    // Low-only multiplies never need A.hi*B.hi
    assign w_last = (r_cnt == ((r_op == 2'b00) ? 2'd2 : 2'd3));
    assign w_nxt_cnt = r_cnt + 2'd1;
    assign w_nxt_a = w_nxt_cnt[0] ? r_a[31:16] : r_a[15:0];
    assign w_nxt_b = w_nxt_cnt[1] ? r_b[31:16] : r_b[15:0];
    // Shift code in 16-bit units: 0, 1, 1, 2
    assign w_sh_in = {1'b0, r_cnt[0]} + {1'b0, r_cnt[1]};

    assign w_ptv  = r_tv[MUL_LATENCY-1];
    assign w_ptl  = r_tl[MUL_LATENCY-1];
    assign w_prod = {32'd0, bus.mc_p}
                  << {r_ts[MUL_LATENCY-1], 4'b0000};
    assign w_acc_nxt = r_acc + (w_ptv ? w_prod : 64'd0);

    // Signed fix-up of the unsigned high word
    assign w_hi_corr = r_acc[63:32]
        - (r_a[31] ? r_b : 32'd0)
        - (((r_op == 2'b10) && r_b[31]) ? r_a : 32'd0);

    assign bus.mc_a = r_mc_a;
    assign bus.mc_b = r_mc_b;
    assign bus.resp_valid  = (r_state == S_DONE);
    assign bus.resp_id     = (r_state == S_DONE) & r_id;
    assign bus.resp_result = (r_state != S_DONE) ? 32'd0
        : (r_op == 2'b00) ? r_acc[31:0] : r_acc[63:32];

    // Tag pipeline pairing each cell product with its shift
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tv <= '0;
            r_tl <= '0;
            for (int i = 0; i < MUL_LATENCY; i++)
                r_ts[i] <= 2'd0;
        end else begin
            r_tv[0] <= (r_state == S_ISSUE);
            r_tl[0] <= (r_state == S_ISSUE) & w_last;
            r_ts[0] <= w_sh_in;
            for (int i = 1; i < MUL_LATENCY; i++) begin
                r_tv[i] <= r_tv[i-1];
                r_tl[i] <= r_tl[i-1];
                r_ts[i] <= r_ts[i-1];
            end
        end
    end

    // Control FSM: accept, issue, drain, correct, respond
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_rr    <= 1'b0;
            r_id    <= 1'b0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_op    <= 2'd0;
            r_cnt   <= 2'd0;
            r_acc   <= 64'd0;
            r_mc_a  <= 16'd0;
            r_mc_b  <= 16'd0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_take) begin
                        r_a     <= w_a_in;
                        r_b     <= w_b_in;
                        r_op    <= w_op_in;
                        r_id    <= w_gnt;
                        r_rr    <= ~w_gnt;
                        r_acc   <= 64'd0;
                        r_cnt   <= 2'd0;
                        r_mc_a  <= w_a_in[15:0];
                        r_mc_b  <= w_b_in[15:0];
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_acc <= w_acc_nxt;
                    if (w_last) begin
                        r_mc_a  <= 16'd0;
                        r_mc_b  <= 16'd0;
                        r_state <= S_DRAIN;
                    end else begin
                        r_cnt  <= w_nxt_cnt;
                        r_mc_a <= w_nxt_a;
                        r_mc_b <= w_nxt_b;
                    end
                end
                S_DRAIN: begin
                    r_acc <= w_acc_nxt;
                    if (w_ptv && w_ptl)
                        r_state <= r_op[1] ? S_CORR : S_DONE;
                end
                S_CORR: begin
                    r_acc[63:32] <= w_hi_corr;
                    r_state      <= S_DONE;
                end
                S_DONE: begin
                    if (bus.resp_ready)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nios2_mul_seq_arbiter.sv
// Directed bench for the sequenced multiply arbiter,
// with a one-cycle registered 16x16 cell model.
module tb_nios2_mul_seq_arbiter;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;

    nios2_mul_seq_arbiter_if bus();

    nios2_mul_seq_arbiter #(.MUL_LATENCY(1)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Shared cell: registered unsigned 16x16
    always @(posedge clk)
        bus.mc_p <= {16'd0, bus.mc_a} * {16'd0, bus.mc_b};

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req0_valid = 0; bus.req0_src1 = 0;
        bus.req0_src2 = 0;  bus.req0_op = 0;
        bus.req1_valid = 0; bus.req1_src1 = 0;
        bus.req1_src2 = 0;  bus.req1_op = 0;
    endtask

    task automatic accept(input bit rq,
                          input logic [31:0] a,
                          input logic [31:0] b,
                          input logic [1:0] op);
        if (!rq) begin
            bus.req0_valid = 1; bus.req0_src1 = a;
            bus.req0_src2 = b;  bus.req0_op = op;
        end else begin
            bus.req1_valid = 1; bus.req1_src1 = a;
            bus.req1_src2 = b;  bus.req1_op = op;
        end
        #1;
        check("accept_ready",
              rq ? bus.req1_ready : bus.req0_ready, 1);
        tick();
        bus.req0_valid = 0;
        bus.req1_valid = 0;
        cyc = 1;
    endtask

    task automatic wait_resp(input int exp_lat);
        while (!bus.resp_valid && cyc < 40) begin
            tick();
            cyc++;
        end
        check("latency", cyc, exp_lat);
    endtask

    task automatic finish_op(input logic [31:0] exp_res,
                             input logic exp_id,
                             input int exp_lat);
        wait_resp(exp_lat);
        check("result", bus.resp_result, exp_res);
        check("resp_id", {31'd0, bus.resp_id}, {31'd0, exp_id});
        tick();
        check("idle_after", {31'd0, bus.resp_valid}, 0);
    endtask

    task automatic check_zero_outs(input string tag);
        check({tag, "_rv"}, {31'd0, bus.resp_valid}, 0);
        check({tag, "_res"}, bus.resp_result, 0);
        check({tag, "_id"}, {31'd0, bus.resp_id}, 0);
        check({tag, "_mc"}, {bus.mc_a, bus.mc_b}, 0);
        check({tag, "_rdy"},
              {30'd0, bus.req1_ready, bus.req0_ready}, 0);
    endtask

    int  ng;
    int  nr;
    bit  busy;
    bit  seen;

    initial begin
        idle_inputs();
        bus.resp_ready = 1;
        bus.req0_valid = 1;
        repeat (2) tick();
        check_zero_outs("reset");
        bus.req0_valid = 0;
        reset_n = 1;
        tick();

        // mul-low with partial-product order
        accept(0, 32'h0001_2345, 32'h0000_0010, 2'b00);
        check("mc0", {bus.mc_a, bus.mc_b}, 32'h2345_0010);
        tick(); cyc++;
        check("mc1", {bus.mc_a, bus.mc_b}, 32'h0001_0010);
        tick(); cyc++;
        check("mc2", {bus.mc_a, bus.mc_b}, 32'h2345_0000);
        tick(); cyc++;
        check("mc_drain", {bus.mc_a, bus.mc_b}, 0);
        finish_op(32'h0012_3450, 0, 5);

        // unsigned high, requester 1
        accept(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b01);
        finish_op(32'hFFFF_FFFE, 1, 6);

        // signed high words
        accept(0, 32'hFFFF_FFFF, 32'h0000_0002, 2'b10);
        finish_op(32'hFFFF_FFFF, 0, 7);
        accept(0, 32'h8000_0000, 32'h8000_0000, 2'b11);
        finish_op(32'hC000_0000, 0, 7);
        accept(1, 32'h8000_0000, 32'h8000_0000, 2'b10);
        finish_op(32'h4000_0000, 1, 7);

        // both requesters contending after reset
        reset_n = 0;
        tick();
        reset_n = 1;
        tick();
        bus.req0_valid = 1; bus.req0_src1 = 3;
        bus.req0_src2 = 5;  bus.req0_op = 0;
        bus.req1_valid = 1; bus.req1_src1 = 7;
        bus.req1_src2 = 9;  bus.req1_op = 0;
        #1;
        ng = 0; nr = 0; busy = 0;
        for (int c = 0; c < 200 && nr < 4; c++) begin
            if (bus.req0_ready || bus.req1_ready) begin
                check("gnt_busy", {31'd0, busy}, 0);
                check("gnt_order",
                      {31'd0, bus.req1_ready}, ng % 2);
                busy = 1;
                ng++;
            end
            if (bus.resp_valid) begin
                check("rr_id", {31'd0, bus.resp_id}, nr % 2);
                check("rr_res", bus.resp_result,
                      bus.resp_id ? 32'd63 : 32'd15);
                busy = 0;
                nr++;
            end
            tick();
        end
        check("rr_count", nr, 4);
        idle_inputs();
        tick();

        // back-pressure on the response
        bus.resp_ready = 0;
        accept(0, 32'h0001_2345, 32'h0000_0010, 2'b00);
        wait_resp(5);
        bus.req0_valid = 1;
        bus.req1_valid = 1;
        #1;
        for (int k = 0; k < 3; k++) begin
            check("hold_res", bus.resp_result, 32'h0012_3450);
            check("hold_id", {31'd0, bus.resp_id}, 0);
            check("hold_rdy",
                  {30'd0, bus.req1_ready, bus.req0_ready}, 0);
            check("hold_mc", {bus.mc_a, bus.mc_b}, 0);
            tick();
        end
        bus.resp_ready = 1;
        tick();
        check("hs_idle_rv", {31'd0, bus.resp_valid}, 0);
        check("hs_idle_rdy1", {31'd0, bus.req1_ready}, 1);
        idle_inputs();
        #1;
        tick();

        // reset in the middle of an issue
        accept(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b01);
        tick();
        reset_n = 0;
        bus.req0_valid = 1;
        #1;
        check_zero_outs("midrst");
        tick();
        bus.req0_valid = 0;
        tick();
        reset_n = 1;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bus.resp_valid) seen = 1;
        end
        check("no_resp", {31'd0, seen}, 0);
        bus.req0_valid = 1; bus.req0_src1 = 32'h0001_0000;
        bus.req0_src2 = 32'h0001_0000; bus.req0_op = 2'b01;
        bus.req1_valid = 1; bus.req1_src1 = 32'h0001_0000;
        bus.req1_src2 = 32'h0001_0000; bus.req1_op = 2'b01;
        #1;
        check("prio_rdy0", {31'd0, bus.req0_ready}, 1);
        check("prio_rdy1", {31'd0, bus.req1_ready}, 0);
        tick();
        idle_inputs();
        cyc = 1;
        finish_op(32'h0000_0001, 0, 6);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/nios2_mul_seq_arbiter.md
Name: nios2_mul_seq_arbiter

Overview:
- Sequences 32x32 multiplies for the Nios II custom-multiply path through a single shared, registered 16x16 unsigned multiplier cell.
- Produces the low-32 result (mul) or the high-32 result (mulxuu, mulxss, mulxsu) by issuing 16-bit partial products and accumulating them into 64 bits.
- Arbitrates the shared cell round-robin between two requesters (CPU pipeline, custom-instruction port).
- Sits between the requesters and the hardware-multiplier cell.

Parameters:
- MUL_LATENCY, 1, cycles from mc_a/mc_b issue to the matching mc_p (1..3).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 request
- req0_ready  out  1  requester 0 accepted
- req0_src1  in  32  operand A
- req0_src2  in  32  operand B
- req0_op  in  2  00 mul-low, 01 mulxuu, 10 mulxss, 11 mulxsu (src1 signed, src2 unsigned)
- req1_valid/req1_ready/req1_src1/req1_src2/req1_op  same widths and meaning for requester 1
- mc_a  out  16  multiplier cell operand A
- mc_b  out  16  multiplier cell operand B
- mc_p  in  32  multiplier cell product, unsigned, MUL_LATENCY after issue
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts result
- resp_result  out  32  result word
- resp_id  out  1  requester that owns the result

Behaviour:
- Reset (async, reset_n=0): state IDLE; rr pointer favours requester 0; all outputs 0, including resp_valid, resp_result, resp_id, req*_ready, mc_a and mc_b. Accumulator and operand latches cleared. Reset mid-operation aborts the operation with no response.
- States and transitions:
  - IDLE: reqN_ready = grant AND reqN_valid, combinational, asserted in IDLE only. Single valid request: grant it. Both valid: grant the rr pointer; pointer then moves to the other requester. Acceptance latches src1, src2, op and id, then goes to ISSUE.
  - ISSUE: one partial product per cycle, in order A.lo*B.lo (shift 0), A.hi*B.lo (shift 16), A.lo*B.hi (shift 16), A.hi*B.hi (shift 32). op 00 skips the 4th product (N=3); other ops use N=4. mc_a/mc_b hold 0 outside ISSUE.
  - DRAIN: wait for the last product. A shift tag pipeline of depth MUL_LATENCY aligns each mc_p with its shift. Accumulation is a 64-bit add, with carries discarded above bit 63.
  - CORR (op 10/11 only): hi32 -= (src1[31] ? src2 : 0). For op 10 also hi32 -= (src2[31] ? src1 : 0). Arithmetic is modulo 2^32.
  - DONE: resp_valid=1. resp_result = acc[31:0] for op 00, else acc[63:32]. resp_id = latched id. Result and id are held stable while resp_ready=0. On the resp_valid & resp_ready cycle go to IDLE; the next accept happens no earlier than the following cycle.
- Latency, with accept at cycle 0: resp_valid rises at cycle N+MUL_LATENCY+1, plus 1 for signed ops. At MUL_LATENCY=1 this is 5 (mul), 6 (mulxuu), 7 (mulxss/mulxsu).
- One operation in flight at a time. Requests arriving in non-IDLE states see ready=0 and must hold their valid.
- Round-robin pointer updates only on a grant. A lone requester is granted back-to-back.

Test Plan:
- req0 op00, src1=0x00012345, src2=0x00000010, MUL_LATENCY=1 -> resp_valid at cycle 5, resp_result=0x00123450, resp_id=0; mc_a/mc_b sequence 0x2345/0x0010, 0x0001/0x0010, 0x2345/0x0000.
- req1 op01, src1=src2=0xFFFFFFFF -> resp_result=0xFFFFFFFE, resp_id=1, resp_valid at cycle 6.
- Signed: op10 with 0xFFFFFFFF and 0x00000002 -> 0xFFFFFFFF at cycle 7. op11 with 0x80000000 and 0x80000000 -> 0xC0000000. op10 with 0x80000000 and 0x80000000 -> 0x40000000.
- Both requesters continuously valid after reset, resp_ready=1 -> grants ordered 0,1,0,1. A grant is never given while busy. resp_id alternates.
- resp_ready held 0 for 3 cycles in DONE -> resp_result and resp_id stable, req0_ready/req1_ready stay 0, mc_a/mc_b stay 0; IDLE the cycle after the handshake.
- reset_n pulsed low during ISSUE of an op01 -> immediate all-zero outputs, no response. A request after reset completes correctly with requester 0 priority.
